dma_channel_arbiter: RTL and testbench

Selects one DMA channel for the single shared transfer engine. Channels can request at the same time; the winner is picked by a 2-bit priority, and ties are broken round-robin. The block offers the winner to the engine with a valid/ready handshake, holds the grant until the engine reports completion, then pulses an acknowledge back to that channel's requester. It sits between the per-channel request lines and the engine's channel-select input.

---
 rtl/dma_channel_arbiter_if.sv | 23 ++
 rtl/dma_channel_arbiter.sv | 111 +++++++++++
 tb/tb_dma_channel_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_channel_arbiter_if.sv
// Engine-side handshake of the DMA channel arbiter: offer (valid/channel/one-hot),
// accept (dma_ready_i), completion (trans_done_i) and busy status.
interface dma_channel_arbiter_if #(
   parameter int CHANNELS_AMOUNT = 4,
   parameter int CHAN_W          = (CHANNELS_AMOUNT > 1) ? $clog2(CHANNELS_AMOUNT) : 1
);
   logic                       arb_req_valid_o;
   logic [CHAN_W-1:0]          arb_req_channel_o;
   logic                       dma_ready_i;
   logic                       trans_done_i;
   logic                       busy_o;
   logic [CHANNELS_AMOUNT-1:0] grant_onehot_o;

   modport master (
      output arb_req_valid_o, arb_req_channel_o, busy_o, grant_onehot_o,
      input  dma_ready_i, trans_done_i
   );

   modport slave (
      input  arb_req_valid_o, arb_req_channel_o, busy_o, grant_onehot_o,
      output dma_ready_i, trans_done_i
   );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Priority + round-robin channel arbiter for one shared DMA engine; offer valid one cycle after an
// eligible request is sampled, held stable until dma_ready_i, grant held until trans_done_i, then a one-cycle ack.
module dma_channel_arbiter #(
   parameter int  CHANNELS_AMOUNT = 4,
   parameter int  PRIO_W          = 2,
   localparam int CHAN_W          = (CHANNELS_AMOUNT > 1) ? $clog2(CHANNELS_AMOUNT) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [CHANNELS_AMOUNT-1:0]        channel_req_i,
   input  logic [CHANNELS_AMOUNT-1:0]        channel_en_i,
   input  logic [CHANNELS_AMOUNT*PRIO_W-1:0] channel_prio_i,
   output logic [CHANNELS_AMOUNT-1:0]        channel_ack_o,
   dma_channel_arbiter_if.master             eng
);

   typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

   localparam logic [CHANNELS_AMOUNT-1:0] ONE_HOT0 = CHANNELS_AMOUNT'(1);

   state_t                     state;
   logic [CHANNELS_AMOUNT-1:0] rearm;
   logic [CHANNELS_AMOUNT-1:0] eligible;
   logic [CHAN_W-1:0]          last_grant;
   logic [CHAN_W-1:0]          sel_idx;
   logic [CHAN_W-1:0]          scan_w;
   logic [PRIO_W-1:0]          sel_prio;
   logic [PRIO_W-1:0]          prio_arr [CHANNELS_AMOUNT];
   logic                       sel_found;
   int                         scan_idx;

   // Scan starts just after the last accepted channel; strict '>' keeps the first
   // equal-priority hit, which is what makes ties round-robin.
   always_comb begin
      eligible  = channel_req_i & channel_en_i & rearm;
      sel_idx   = '0;
      sel_prio  = '0;
      sel_found = 1'b0;
      scan_idx  = 0;
      scan_w    = '0;
      for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
         prio_arr[i] = channel_prio_i[i*PRIO_W +: PRIO_W];
      end
      for (int k = 1; k <= CHANNELS_AMOUNT; k++) begin
         scan_idx = int'(last_grant) + k;
         if (scan_idx >= CHANNELS_AMOUNT) begin
            scan_idx = scan_idx - CHANNELS_AMOUNT;
         end
         scan_w = CHAN_W'(scan_idx);
         if (eligible[scan_w] && (!sel_found || (prio_arr[scan_w] > sel_prio))) begin
            sel_found = 1'b1;
            sel_prio  = prio_arr[scan_w];
            sel_idx   = scan_w;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state                 <= IDLE;
         eng.arb_req_valid_o   <= 1'b0;
         eng.arb_req_channel_o <= '0;
         eng.busy_o            <= 1'b0;
         eng.grant_onehot_o    <= '0;
         channel_ack_o         <= '0;
         last_grant            <= CHAN_W'(CHANNELS_AMOUNT - 1);
         rearm                 <= '1;
      end else begin
         channel_ack_o <= '0;
         rearm         <= rearm | ~channel_req_i;
         case (state)
            IDLE: begin
               if (sel_found) begin
                  eng.arb_req_channel_o <= sel_idx;
                  eng.grant_onehot_o    <= ONE_HOT0 << sel_idx;
                  eng.arb_req_valid_o   <= 1'b1;
                  state                 <= OFFER;
               end
            end
            OFFER: begin
               if (eng.dma_ready_i) begin
                  eng.arb_req_valid_o <= 1'b0;
                  eng.busy_o          <= 1'b1;
                  last_grant          <= eng.arb_req_channel_o;
                  state               <= BUSY;
               end else if (!(channel_req_i[eng.arb_req_channel_o] &&
                              channel_en_i[eng.arb_req_channel_o])) begin
                  eng.arb_req_valid_o <= 1'b0;
                  eng.grant_onehot_o  <= '0;
                  state               <= IDLE;
               end
            end
            BUSY: begin
               // Rearm is cleared even when the ack is suppressed, so a disabled
               // channel still has to drop its request before it can win again.
               if (eng.trans_done_i) begin
                  eng.busy_o                       <= 1'b0;
                  eng.grant_onehot_o               <= '0;
                  rearm[eng.arb_req_channel_o]     <= 1'b0;
                  if (channel_en_i[eng.arb_req_channel_o]) begin
                     channel_ack_o <= ONE_HOT0 << eng.arb_req_channel_o;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter: stimulus pushes expected offers/acks into a queue,
// a negedge monitor pops and compares whenever an offer starts or an ack pulses.
module tb_dma_channel_arbiter;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [3:0] req;
   logic [3:0] en;
   logic [7:0] prio;
   logic [3:0] ack;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit is_ack;
      int ch;
   } ev_t;

   ev_t exp_q[$];
   bit  prev_valid = 1'b0;

   dma_channel_arbiter_if #(.CHANNELS_AMOUNT(4)) ifc ();

   dma_channel_arbiter #(
      .CHANNELS_AMOUNT(4),
      .PRIO_W         (2)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .channel_req_i (req),
      .channel_en_i  (en),
      .channel_prio_i(prio),
      .channel_ack_o (ack),
      .eng           (ifc)
   );

   always #5 clk_i = ~clk_i;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic expect_ev(input bit is_ack, input int ch);
      ev_t e;
      e.is_ack = is_ack;
      e.ch     = ch;
      exp_q.push_back(e);
   endtask

   task automatic mon_pop(input bit is_ack, input int ch, input int bits);
      ev_t e;
      int  want_bits;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_%s: got ch=%0d bits=%0h want no event",
                  is_ack ? "ack" : "offer", ch, bits);
      end else begin
         e         = exp_q.pop_front();
         want_bits = 1 << e.ch;
         if ((e.is_ack != is_ack) || (!is_ack && (ch != e.ch)) || (bits != want_bits)) begin
            bad++;
            $display("FAIL event_%s: got ch=%0d bits=%0h want %s ch=%0d bits=%0h",
                     is_ack ? "ack" : "offer", ch, bits,
                     e.is_ack ? "ack" : "offer", e.ch, want_bits);
         end
      end
   endtask

   always @(negedge clk_i) begin
      if (ifc.arb_req_valid_o && !prev_valid) begin
         mon_pop(1'b0, int'(ifc.arb_req_channel_o), int'(ifc.grant_onehot_o));
      end
      if (ack != 4'b0000) begin
         mon_pop(1'b1, -1, int'(ack));
      end
      prev_valid = ifc.arb_req_valid_o;
   end

   task automatic wait_valid(input string name);
      int n = 0;
      while (!ifc.arb_req_valid_o && (n < 20)) begin
         cyc(1);
         n++;
      end
      if (!ifc.arb_req_valid_o) begin
         total++;
         bad++;
         $display("FAIL %s: valid=0 want 1 within 20 cycles", name);
      end
   endtask

   // Accept the pending offer, then report completion done_dly cycles after the accept edge.
   task automatic serve(input string name, input int done_dly);
      wait_valid(name);
      ifc.dma_ready_i = 1'b1;
      cyc(1);
      ifc.dma_ready_i = 1'b0;
      repeat (done_dly - 1) cyc(1);
      ifc.trans_done_i = 1'b1;
      cyc(1);
      ifc.trans_done_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      cyc(2);
      rst_i = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rr_order [6] = '{0, 1, 2, 3, 0, 1};
      rst_i            = 1'b0;
      req              = '0;
      en               = 4'hF;
      prio             = '0;
      ifc.dma_ready_i  = 1'b0;
      ifc.trans_done_i = 1'b0;
      cyc(3);
      check("rst_valid", int'(ifc.arb_req_valid_o), 0);
      check("rst_busy", int'(ifc.busy_o), 0);
      check("rst_onehot", int'(ifc.grant_onehot_o), 0);
      check("rst_channel", int'(ifc.arb_req_channel_o), 0);
      check("rst_ack", int'(ack), 0);
      rst_i = 1'b1;
      cyc(1);

      // Single request: timing of offer, accept and ack.
      expect_ev(1'b0, 2);
      req[2] = 1'b1;
      check("t1_valid_before", int'(ifc.arb_req_valid_o), 0);
      cyc(1);
      check("t1_valid", int'(ifc.arb_req_valid_o), 1);
      check("t1_channel", int'(ifc.arb_req_channel_o), 2);
      cyc(1);
      ifc.dma_ready_i = 1'b1;
      cyc(1);
      check("t1_busy", int'(ifc.busy_o), 1);
      check("t1_valid_accepted", int'(ifc.arb_req_valid_o), 0);
      ifc.dma_ready_i = 1'b0;
      req[2] = 1'b0;
      cyc(2);
      expect_ev(1'b1, 2);
      ifc.trans_done_i = 1'b1;
      cyc(1);
      ifc.trans_done_i = 1'b0;
      check("t1_ack", int'(ack), 4);
      check("t1_busy_done", int'(ifc.busy_o), 0);
      check("t1_onehot_done", int'(ifc.grant_onehot_o), 0);
      cyc(1);
      check("t1_ack_one_cycle", int'(ack), 0);

      // Priority: ch3 (prio 3) beats ch1 (prio 1).
      prio = {2'd3, 2'd0, 2'd1, 2'd0};
      expect_ev(1'b0, 3);
      expect_ev(1'b1, 3);
      expect_ev(1'b0, 1);
      expect_ev(1'b1, 1);
      req = 4'b1010;
      serve("t2_ch3", 2);
      req[3] = 1'b0;
      serve("t2_ch1", 2);
      req[1] = 1'b0;
      cyc(2);

      // Round-robin among equal priorities.
      do_reset();
      prio = 8'hAA;
      foreach (rr_order[i]) begin
         expect_ev(1'b0, rr_order[i]);
         expect_ev(1'b1, rr_order[i]);
      end
      req = 4'hF;
      for (int i = 0; i < 6; i++) begin
         serve("t3_rr", 3);
         if (i == 5) begin
            req = '0;
         end else begin
            req[rr_order[i]] = 1'b0;
            cyc(1);
            req[rr_order[i]] = 1'b1;
         end
      end
      cyc(2);

      // Rearm: ch0 held high is not re-offered until it drops for a cycle.
      do_reset();
      prio = '0;
      expect_ev(1'b0, 0);
      expect_ev(1'b1, 0);
      req = 4'b0001;
      serve("t4_ch0", 2);
      expect_ev(1'b0, 1);
      expect_ev(1'b1, 1);
      req[1] = 1'b1;
      serve("t4_ch1", 2);
      req[1] = 1'b0;
      cyc(5);
      check("t4_no_reoffer", int'(ifc.arb_req_valid_o), 0);
      expect_ev(1'b0, 0);
      expect_ev(1'b1, 0);
      req[0] = 1'b0;
      cyc(1);
      req[0] = 1'b1;
      serve("t4_ch0_again", 2);
      req[0] = 1'b0;
      cyc(2);

      // Withdraw on enable drop, then accept winning over a same-cycle disable.
      prio = 8'b0000_0001;
      expect_ev(1'b0, 0);
      req = 4'b0011;
      wait_valid("t5_offer0");
      cyc(1);
      en[0] = 1'b0;
      expect_ev(1'b0, 1);
      cyc(1);
      check("t5_withdraw_valid", int'(ifc.arb_req_valid_o), 0);
      check("t5_withdraw_onehot", int'(ifc.grant_onehot_o), 0);
      cyc(1);
      check("t5_ch1_valid", int'(ifc.arb_req_valid_o), 1);
      expect_ev(1'b1, 1);
      serve("t5_ch1", 2);
      req[1] = 1'b0;
      en[0]  = 1'b1;
      expect_ev(1'b0, 0);
      cyc(1);
      check("t5_reoffer0", int'(ifc.arb_req_valid_o), 1);
      ifc.dma_ready_i = 1'b1;
      en[0] = 1'b0;
      cyc(1);
      ifc.dma_ready_i = 1'b0;
      check("t5_accept_busy", int'(ifc.busy_o), 1);
      check("t5_accept_channel", int'(ifc.arb_req_channel_o), 0);
      check("t5_accept_valid", int'(ifc.arb_req_valid_o), 0);
      en[0] = 1'b1;
      cyc(1);
      expect_ev(1'b1, 0);
      ifc.trans_done_i = 1'b1;
      cyc(1);
      ifc.trans_done_i = 1'b0;
      req[0] = 1'b0;
      cyc(2);

      // Reset while busy, then disable the active channel before completion.
      prio = '0;
      expect_ev(1'b0, 2);
      req = 4'b0101;
      wait_valid("t6_offer2");
      ifc.dma_ready_i = 1'b1;
      cyc(1);
      ifc.dma_ready_i = 1'b0;
      check("t6_busy", int'(ifc.busy_o), 1);
      cyc(1);
      rst_i = 1'b0;
      cyc(1);
      check("t6_rst_valid", int'(ifc.arb_req_valid_o), 0);
      check("t6_rst_busy", int'(ifc.busy_o), 0);
      check("t6_rst_onehot", int'(ifc.grant_onehot_o), 0);
      check("t6_rst_ack", int'(ack), 0);
      check("t6_rst_channel", int'(ifc.arb_req_channel_o), 0);
      expect_ev(1'b0, 0);
      rst_i = 1'b1;
      cyc(1);
      check("t6_first_after_rst", int'(ifc.arb_req_channel_o), 0);
      expect_ev(1'b1, 0);
      expect_ev(1'b0, 2);
      serve("t6_ch0", 2);
      req[0] = 1'b0;
      wait_valid("t6_offer2_again");
      ifc.dma_ready_i = 1'b1;
      cyc(1);
      ifc.dma_ready_i = 1'b0;
      en[2] = 1'b0;
      cyc(1);
      ifc.trans_done_i = 1'b1;
      cyc(1);
      ifc.trans_done_i = 1'b0;
      check("t6_dis_busy", int'(ifc.busy_o), 0);
      check("t6_dis_ack", int'(ack), 0);
      check("t6_dis_onehot", int'(ifc.grant_onehot_o), 0);
      en[2] = 1'b1;
      cyc(3);
      check("t6_dis_no_reoffer", int'(ifc.arb_req_valid_o), 0);
      req = '0;
      cyc(2);

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
